// File: rtl/ota_pdm_driver.sv
// ota_pdm_driver: queued signed codes to complementary first-order sigma-delta streams
// driving the OTA Vip/Vin pair, each code held for in_hold+1 samples.
module ota_pdm_driver #(
   parameter int WIDTH  = 8,
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_code,
   input  logic [HOLD_W-1:0] in_hold,
   output logic              Vip,
   output logic              Vin,
   output logic              busy,
   output logic              done
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t             state;
   logic [WIDTH-1:0]   u;
   logic [WIDTH-1:0]   acc;
   logic [HOLD_W-1:0]  cnt;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   u_in;
   logic               xfer;
   always_comb begin
      in_ready = (state == IDLE) ? 1'b1 : ((cnt == '0) & en);
      xfer     = in_valid & in_ready;
      sum      = {1'b0, acc} + {1'b0, u};
      u_in     = {~in_code[WIDTH-1], in_code[WIDTH-2:0]};
      busy     = (state == RUN);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         u     <= '0;
         acc   <= '0;
         cnt   <= '0;
         Vip   <= 1'b0;
         Vin   <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            Vip <= 1'b0;
            Vin <= 1'b0;
            if (xfer) begin
               u     <= u_in;
               cnt   <= in_hold;
               acc   <= '0;
               state <= RUN;
            end
         end else if (en) begin
            acc <= sum[WIDTH-1:0];
            Vip <= sum[WIDTH];
            Vin <= ~sum[WIDTH];
            // acc is kept across a follow-on code so the noise shaping stays continuous
            if (cnt != '0) cnt <= cnt - 1'b1;
            else if (xfer) begin
               u   <= u_in;
               cnt <= in_hold;
            end else begin
               state <= IDLE;
               done  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ota_pdm_driver.sv
// tb_ota_pdm_driver: scoreboard bench; stimulus pushes hand-derived sample streams,
// a monitor pops one entry per emitted sample and compares Vip/Vin/done.
module tb_ota_pdm_driver;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_code = '0;
   logic [7:0] in_hold = '0;
   logic       in_ready, Vip, Vin, busy, done;
   typedef struct packed {logic v; logic d;} exp_t;
   exp_t q[$];
   int   errs = 0;
   int   checks = 0;
   logic fire = 1'b0;
   logic chk_idle = 1'b0;
   ota_pdm_driver #(.WIDTH(8), .HOLD_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_hold(in_hold), .Vip(Vip), .Vin(Vin), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask
   // a new sample is emitted at every edge where the block runs with en high
   always @(posedge clk) fire <= busy & en & ~rst;
   always @(negedge clk) begin
      exp_t e;
      if (fire) begin
         if (q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL extra_sample: got Vip=%b with no sample expected", Vip);
         end else begin
            e = q.pop_front();
            chk("vip", 32'(Vip), 32'(e.v));
            chk("vin", 32'(Vin), 32'(!e.v));
            chk("done", 32'(done), 32'(e.d));
            chk_idle = e.d;
         end
      end else begin
         if (chk_idle) begin
            chk("idle_vip", 32'(Vip), 0);
            chk("idle_vin", 32'(Vin), 0);
            chk("idle_busy", 32'(busy), 0);
         end
         chk_idle = 1'b0;
         chk("no_done", 32'(done), 0);
      end
   end
   task automatic push1(input logic v, input logic d);
      exp_t e;
      e.v = v;
      e.d = d;
      q.push_back(e);
   endtask
   task automatic push_seq(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) push1(v[i], i == n - 1);
   endtask
   task automatic send(input logic [7:0] c, input logic [7:0] h);
      logic rdy;
      int   n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = c;
      in_hold  = h;
      forever begin
         #1 rdy = in_ready;
         @(posedge clk);
         if (rdy) break;
         n++;
         if (n > 1000) begin
            $display("FAIL send_timeout: got no in_ready in %0d cycles expected acceptance", n);
            $fatal(1);
         end
         @(negedge clk);
      end
   endtask
   task automatic idle_in();
      @(negedge clk);
      in_valid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain_timeout: got %0d samples pending expected 0", q.size());
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_vip", 32'(Vip), 0);
      chk("rst_vin", 32'(Vin), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(in_ready), 1);
      // zero code: alternating 0,1
      push_seq(16'b10101010, 8);
      send(8'd0, 8'd7);
      idle_in();
      drain();
      // negative full scale: all zeros
      push_seq(16'b0000, 4);
      send(8'h80, 8'd3);
      idle_in();
      drain();
      // back-to-back 64 then -64 with in_valid held
      push_seq(16'b10001110, 8);
      send(8'd64, 8'd3);
      send(8'hC0, 8'd3);
      idle_in();
      drain();
      // stall of 3 cycles after the 2nd sample
      push_seq(16'b10101010, 8);
      send(8'd0, 8'd7);
      idle_in();
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_vip", 32'(Vip), 1);
         chk("stall_ready", 32'(in_ready), 0);
         chk("stall_busy", 32'(busy), 1);
      end
      en = 1'b1;
      drain();
      // stall with cnt==0: offered code must be refused
      push1(1'b0, 1'b1);
      send(8'h80, 8'd0);
      @(negedge clk);
      en = 1'b0;
      in_code = 8'd0;
      in_hold = 8'd5;
      #1 chk("stall0_ready", 32'(in_ready), 0);
      @(negedge clk);
      chk("stall0_ready2", 32'(in_ready), 0);
      en = 1'b1;
      in_valid = 1'b0;
      drain();
      // reset mid-stream, next code must start from acc = 0
      push1(1'b0, 1'b0);
      push1(1'b1, 1'b0);
      push1(1'b0, 1'b0);
      send(8'd0, 8'd7);
      idle_in();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_vip", 32'(Vip), 0);
      chk("mid_rst_vin", 32'(Vin), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_ready", 32'(in_ready), 1);
      push_seq(16'b1110, 4);
      send(8'd64, 8'd3);
      idle_in();
      drain();
      // positive full scale: one zero then 255 ones
      push1(1'b0, 1'b0);
      for (int i = 0; i < 254; i++) push1(1'b1, 1'b0);
      push1(1'b1, 1'b1);
      send(8'd127, 8'd255);
      idle_in();
      drain();
      chk("queue_empty", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
